goldschmidt_divider: RTL and testbench
======================================

Name: goldschmidt_divider

Overview:
- Self-sequenced Goldschmidt fixed-point divider; parametrised successor to the hand-driven N/D/K datapath.
- Owns its control FSM, initial-approximation ROM, single shared multiplier and start/done handshake. Computes Q = N/D for normalised D in [1,2).
- Used as the division engine in the arithmetic unit; the host issues start and waits for done.

Parameters:
- WIDTH, 16, operand/result width (unsigned fixed point).
- FRAC, 14, fraction bits; format UQ(WIDTH-FRAC).FRAC; WIDTH-FRAC >= 2 required.
- ITERS, 3, Goldschmidt iterations (1..8).
- IA_BITS, 4, D fraction bits indexing the initial-approximation ROM (2^IA_BITS entries).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request; accepted only when ready=1
- n_in  input  WIDTH  dividend, UQ format
- d_in  input  WIDTH  divisor, UQ format, expected in [1.0,2.0)
- ready  output  1  high in IDLE and DONE
- busy  output  1  high in LOAD/MUL_D/MUL_N
- done  output  1  one-cycle pulse, result valid
- err  output  1  divisor out of range, valid with done
- result  output  WIDTH  quotient; held until next accepted start

Behaviour:
- Reset (async): state=IDLE; N,D,K regs, result, done, err = 0; ready=1, busy=0.
- States: IDLE, LOAD, MUL_D, MUL_N, DONE.
- IDLE/DONE + start: capture n_in, d_in; clear iteration counter; go LOAD. DONE without start: go IDLE. DONE lasts exactly one cycle.
- LOAD: if d_in integer field != 1 (D<1.0 or D>=2.0): err<=1, result<=all ones, go DONE. Else K<=ROM[D[FRAC-1 -: IA_BITS]], go MUL_D.
- MUL_D: D<=trunc(D*K); go MUL_N.
- MUL_N: N<=trunc(N*K); K<=(2<<FRAC)-D (mod 2^WIDTH); counter++. If counter==ITERS-1 go DONE with result<=new N, else go MUL_D.
- trunc(x): 2*WIDTH-bit product, keep bits [WIDTH+FRAC-1:FRAC]; higher bits discarded.
- Latency: done asserted 2*ITERS+2 cycles after the start edge (8 for ITERS=3); error case: 2 cycles.
- ROM entry i = floor(2^FRAC * 2^(IA_BITS+1) / (2^(IA_BITS+1)+2i+1)), i.e. 1/midpoint of bucket.
- start while busy: ignored, no state change.
- start in DONE cycle: accepted (back-to-back), done still pulses for the previous op.
- Reset mid-operation: immediate abort to IDLE; no done pulse.
- done and err only change on state transitions; err cleared on next accepted start.

Optional Feature:
- Macro GDIV_ROUND_EN.
- Defined: trunc() replaced by round-half-up, adding 2^(FRAC-1) to each product before bit selection.
- Undefined: pure truncation. Latency and handshake are identical in both builds.

Decomposition:
- Package gdiv_pkg holds the state enum typedef (IDLE, LOAD, MUL_D, MUL_N, DONE) and the ROM-entry constant function.
- One sub-module: gdiv_ia_rom (parameters WIDTH, FRAC, IA_BITS), combinational table built at elaboration.
- The multiplier is inline, with one instance shared between MUL_D and MUL_N.

Test Plan:
- N=0x5000 (1.25), D=0x6000 (1.5), defaults -> done exactly 8 cycles after start; result 0x3555 +/-1 LSB; err=0; ROM index 8 yields K=0x29CB.
- N=0x7FFF, D=0x4000 (1.0) -> result 0x7FFF +/-2 LSB, done at cycle 8.
- D=0x2000 (0.5) and D=0x8000 (2.0) -> err=1, result=0xFFFF, done 2 cycles after start.
- start pulsed again at cycles 3 and 5 of an active op -> ignored; single done at cycle 8; result unchanged by second operands.
- reset raised mid-MUL_N -> outputs 0, ready=1 asynchronously; next start completes normally.
- Back-to-back: start held through the DONE cycle with new operands -> two done pulses 8 cycles apart, both results correct.

Source files
------------

// File: rtl/gdiv_pkg.sv
// Shared types and elaboration-time helpers for the Goldschmidt divider.
package gdiv_pkg;

  typedef enum logic [2:0] {IDLE, LOAD, MUL_D, MUL_N, DONE} state_e;

  // Reciprocal of the midpoint of ROM bucket i, in UQx.frac: 2^(frac+ia+1) / (2^(ia+1) + 2i + 1)
  function automatic longint unsigned ia_entry(input int frac, input int ia_bits, input int i);
    longint unsigned num;
    longint unsigned den;
    num = longint'(1) << (frac + ia_bits + 1);
    den = (longint'(1) << (ia_bits + 1)) + longint'(2 * i + 1);
    return num / den;
  endfunction

endpackage

// File: rtl/gdiv_ia_rom.sv
// Initial-approximation ROM: 1/D seed indexed by the top IA_BITS of D's fraction.
module gdiv_ia_rom
  import gdiv_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 14,
  parameter int IA_BITS = 4
) (
  input  logic [IA_BITS-1:0] idx_i,
  output logic [WIDTH-1:0]   k_o
);

  logic [WIDTH-1:0] rom_w [2**IA_BITS];

  for (genvar g = 0; g < 2**IA_BITS; g++) begin : g_rom
    assign rom_w[g] = WIDTH'(ia_entry(FRAC, IA_BITS, g));
  end

  assign k_o = rom_w[idx_i];

endmodule

// File: rtl/goldschmidt_divider.sv
// Self-sequenced Goldschmidt divider Q = N/D for D in [1,2), one shared multiplier.
// Build option GDIV_ROUND_EN: round-half-up on every product instead of truncation.
module goldschmidt_divider
  import gdiv_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int FRAC    = 14,
  parameter int ITERS   = 3,
  parameter int IA_BITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] n_in,
  input  logic [WIDTH-1:0] d_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = 4;
  localparam int IW = WIDTH - FRAC;
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2) << FRAC;
`ifdef GDIV_ROUND_EN
  localparam logic [PW-1:0] RND = PW'(1) << (FRAC - 1);
`else
  localparam logic [PW-1:0] RND = '0;
`endif

  state_e           state_q;
  logic [WIDTH-1:0] n_q, d_q, k_q, result_q;
  logic [CW-1:0]    cnt_q;
  logic             done_q, err_q, ready_q, busy_q;

  logic [WIDTH-1:0] k_rom;
  logic [WIDTH-1:0] mul_a;
  logic [PW-1:0]    prod;
  logic [WIDTH-1:0] prod_d;
  logic             d_bad;

  gdiv_ia_rom #(.WIDTH(WIDTH), .FRAC(FRAC), .IA_BITS(IA_BITS)) u_rom (
    .idx_i (d_q[FRAC-1 -: IA_BITS]),
    .k_o   (k_rom)
  );

  // Single multiplier: D*K in MUL_D, N*K in MUL_N
  assign mul_a  = (state_q == MUL_N) ? n_q : d_q;
  assign prod   = PW'(mul_a) * PW'(k_q) + RND;
  assign prod_d = WIDTH'(prod >> FRAC);
  assign d_bad  = (d_q[WIDTH-1:FRAC] != IW'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      n_q      <= '0;
      d_q      <= '0;
      k_q      <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start) begin
            n_q     <= n_in;
            d_q     <= d_in;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= LOAD;
          end else begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        LOAD: begin
          if (d_bad) begin
            err_q    <= 1'b1;
            result_q <= '1;
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end else begin
            k_q     <= k_rom;
            state_q <= MUL_D;
          end
        end
        MUL_D: begin
          d_q     <= prod_d;
          state_q <= MUL_N;
        end
        MUL_N: begin
          n_q   <= prod_d;
          k_q   <= TWO - d_q;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(ITERS - 1)) begin
            result_q <= prod_d;
            done_q   <= 1'b1;
            ready_q  <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end else begin
            state_q <= MUL_D;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_goldschmidt_divider.sv
// Randomized self-checking bench for goldschmidt_divider against an arithmetic reference model.
module tb_goldschmidt_divider;

  localparam int W  = 16;
  localparam int F  = 14;
  localparam int IT = 3;
  localparam int IA = 4;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [W-1:0]  n_in, d_in, result;
  logic          ready, busy, done, err;
  logic [IA-1:0] rom_idx;
  logic [W-1:0]  rom_k;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  goldschmidt_divider #(.WIDTH(W), .FRAC(F), .ITERS(IT), .IA_BITS(IA)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .n_in   (n_in),
    .d_in   (d_in),
    .ready  (ready),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .result (result)
  );

  gdiv_ia_rom #(.WIDTH(W), .FRAC(F), .IA_BITS(IA)) u_rom (
    .idx_i (rom_idx),
    .k_o   (rom_k)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned ia_ref(input int i);
    return (longint'(1) << (F + IA + 1)) / ((longint'(1) << (IA + 1)) + longint'(2 * i + 1));
  endfunction

  function automatic longint unsigned mtrunc(input longint unsigned a, input longint unsigned b);
    longint unsigned p;
    p = a * b;
`ifdef GDIV_ROUND_EN
    p = p + (longint'(1) << (F - 1));
`endif
    return (p >> F) & 64'hFFFF;
  endfunction

  // Q = N * prod(K_i), D driven toward 1 by K_{i+1} = 2 - D_i
  function automatic logic [W-1:0] ref_div(input logic [W-1:0] n, input logic [W-1:0] d,
                                           output logic e);
    longint unsigned nn, dd, k;
    if (d < 16'h4000 || d >= 16'h8000) begin
      e = 1'b1;
      return 16'hFFFF;
    end
    e  = 1'b0;
    nn = n;
    dd = d;
    k  = ia_ref(int'(d[F-1 -: IA]));
    for (int i = 0; i < IT; i++) begin
      dd = mtrunc(dd, k);
      nn = mtrunc(nn, k);
      k  = (64'h8000 - dd) & 64'hFFFF;
    end
    return W'(nn);
  endfunction

  task automatic issue(input logic [W-1:0] n, input logic [W-1:0] d);
    @(negedge clk);
    start = 1'b1;
    n_in  = n;
    d_in  = d;
    @(posedge clk);
  endtask

  task automatic wait_done(input bit glitch, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      start = glitch && (lat == 3 || lat == 5);
      if (start) begin
        n_in = W'($urandom);
        d_in = 16'h4000 | W'($urandom_range(0, 16'h3FFF));
      end
      if (lat == 1) check("busy_load", {busy, ready}, 2'b10);
    end while (!done && lat < 40);
    if (!done) check("timeout", 0, 1);
  endtask

  task automatic run(input logic [W-1:0] n, input logic [W-1:0] d, input bit glitch,
                     output logic [W-1:0] q);
    logic e;
    int   lat;
    q = ref_div(n, d, e);
    issue(n, d);
    wait_done(glitch, lat);
    check("latency", lat, e ? 2 : 8);
    check("result", result, q);
    check("err", err, e);
    check("ready_done", {ready, busy}, 2'b10);
  endtask

  logic [W-1:0] q, qb, nb, db;
  logic         eb;
  int           lat;
  int           diff;

  initial begin
    reset = 1'b1;
    start = 1'b0;
    n_in  = '0;
    d_in  = '0;
    #12;
    check("rst_out", {result, done, err, ready, busy}, {16'h0, 4'b0010});
    @(negedge clk);
    reset = 1'b0;

    rom_idx = 4'd8;
    #1 check("rom8", rom_k, 16'h29CB);
    for (int i = 0; i < 2**IA; i++) begin
      rom_idx = IA'(i);
      #1 check("rom", rom_k, ia_ref(i) & 64'hFFFF);
    end

    run(16'h5000, 16'h6000, 1'b0, q);
    diff = int'(result) - 32'h3555;
    check("t1_tol", (diff >= -1 && diff <= 1), 1);

    run(16'h7FFF, 16'h4000, 1'b0, q);
    diff = int'(result) - 32'h7FFF;
    check("t2_tol", (diff >= -2 && diff <= 2), 1);

    run(16'h1234, 16'h2000, 1'b0, q);
    run(16'h1234, 16'h8000, 1'b0, q);

    // Extra starts during the op must be ignored, single done pulse
    run(16'h3A5C, 16'h5B21, 1'b1, q);
    @(negedge clk);
    check("one_pulse", done, 0);

    // Abort from MUL_N by async reset
    issue(16'h6000, 16'h5000);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1 check("abort_out", {result, done, err, ready, busy}, {16'h0, 4'b0010});
    @(negedge clk);
    @(negedge clk);
    check("abort_nodone", done, 0);
    reset = 1'b0;
    run(16'h6000, 16'h5000, 1'b0, q);

    // Back-to-back: start held in the DONE cycle
    run(16'h2222, 16'h7777, 1'b0, q);
    nb = 16'h4321;
    db = 16'h4ABC;
    qb = ref_div(nb, db, eb);
    start = 1'b1;
    n_in  = nb;
    d_in  = db;
    @(posedge clk);
    wait_done(1'b0, lat);
    check("b2b_lat", lat, 8);
    check("b2b_result", result, qb);

    for (int t = 0; t < 40; t++) begin
      logic [W-1:0] rn, rd;
      rn = W'($urandom);
      rd = W'($urandom);
      if ($urandom_range(0, 7) != 0) rd = 16'h4000 | (rd & 16'h3FFF);
      run(rn, rd, 1'b0, q);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
